// File: rtl/tron_game_timer_if.sv
// tron_game_timer_if
// Groups the run/pause control and the timer outputs into one bundle.
//   enable    : run/pause request (1 = run)
//   clk_fast  : divided 50 % duty clock for the cycle datapaths
//   sec_tick  : one-cycle pulse per elapsed second
//   HEX0..3   : active-low 7-segment patterns (s0, s1, m0, m1)
// Modports: master drives enable and observes outputs; slave is the timer.
interface tron_game_timer_if;
    logic       enable;
    logic       clk_fast;
    logic       sec_tick;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;

    modport master (
        output enable,
        input  clk_fast, sec_tick, HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  enable,
        output clk_fast, sec_tick, HEX0, HEX1, HEX2, HEX3
    );
endinterface

// File: rtl/tron_game_timer.sv
// tron_game_timer
// Divides CLOCK_50 into the light-cycle step clock (clk_fast) and a 1 Hz
// tick, keeps an MM:SS game clock that pauses with enable, and drives four
// active-low 7-segment displays.
// Ports:
//   CLOCK_50 : system clock
//   resetn   : synchronous active-low reset, priority over enable
//   bus      : tron_game_timer_if.slave (enable in; clk_fast, sec_tick,
//              HEX0..HEX3 out, all registered)
// Parameters:
//   FAST_DIV : CLOCK_50 cycles per clk_fast period (even, >= 2)
//   SEC_DIV  : CLOCK_50 cycles per sec_tick (>= 2)
// Build option:
//   TIMER_LEADING_BLANK_EN : blank HEX3 when m1=0, and HEX2 when m1=m0=0.
module tron_game_timer #(
    parameter int FAST_DIV = 10_000_000,
    parameter int SEC_DIV  = 50_000_000
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    tron_game_timer_if.slave   bus
);

    localparam int FAST_HALF = FAST_DIV / 2;
    localparam int FW        = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
    localparam int SW        = $clog2(SEC_DIV);

    localparam logic [FW-1:0] FAST_TC = FW'(FAST_HALF - 1);
    localparam logic [SW-1:0] SEC_TC  = SW'(SEC_DIV - 1);
    localparam logic [6:0]    SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [FW-1:0] fast_cnt_q, fast_cnt_d;
    logic [SW-1:0] sec_cnt_q,  sec_cnt_d;
    logic          clk_fast_q, clk_fast_d;
    logic          sec_tick_q, sec_tick_d;
    logic [3:0]    s0_q, s0_d, s1_q, s1_d, m0_q, m0_d, m1_q, m1_d;
    logic [6:0]    hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;

    always_comb begin
        fast_cnt_d = fast_cnt_q;
        clk_fast_d = clk_fast_q;
        sec_cnt_d  = sec_cnt_q;
        sec_tick_d = 1'b0;
        s0_d       = s0_q;
        s1_d       = s1_q;
        m0_d       = m0_q;
        m1_d       = m1_q;

        // A paused cycle sitting on terminal count leaves the counter there,
        // so the event fires on the first cycle after resuming.
        if (bus.enable) begin
            if (fast_cnt_q == FAST_TC) begin
                fast_cnt_d = '0;
                clk_fast_d = ~clk_fast_q;
            end else begin
                fast_cnt_d = fast_cnt_q + 1'b1;
            end

            if (sec_cnt_q == SEC_TC) begin
                sec_cnt_d  = '0;
                sec_tick_d = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
        end

        // Digits advance on the edge that retires the tick. A tick already
        // issued is honoured even if enable drops in that cycle, so an
        // announced second is never lost from the game clock.
        if (sec_tick_q) begin
            if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                if (s1_q == 4'd5) begin
                    s1_d = 4'd0;
                    if (m0_q == 4'd9) begin
                        m0_d = 4'd0;
                        m1_d = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
                    end else begin
                        m0_d = m0_q + 4'd1;
                    end
                end else begin
                    s1_d = s1_q + 4'd1;
                end
            end else begin
                s0_d = s0_q + 4'd1;
            end
        end

        hex0_d = seg7(s0_q);
        hex1_d = seg7(s1_q);
`ifdef TIMER_LEADING_BLANK_EN
        hex2_d = (m1_q == 4'd0 && m0_q == 4'd0) ? SEG_BLANK : seg7(m0_q);
        hex3_d = (m1_q == 4'd0) ? SEG_BLANK : seg7(m1_q);
`else
        hex2_d = seg7(m0_q);
        hex3_d = seg7(m1_q);
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            fast_cnt_q <= '0;
            sec_cnt_q  <= '0;
            clk_fast_q <= 1'b0;
            sec_tick_q <= 1'b0;
            s0_q       <= 4'd0;
            s1_q       <= 4'd0;
            m0_q       <= 4'd0;
            m1_q       <= 4'd0;
            hex0_q     <= SEG_ZERO;
            hex1_q     <= SEG_ZERO;
            hex2_q     <= SEG_ZERO;
            hex3_q     <= SEG_ZERO;
        end else begin
            fast_cnt_q <= fast_cnt_d;
            sec_cnt_q  <= sec_cnt_d;
            clk_fast_q <= clk_fast_d;
            sec_tick_q <= sec_tick_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
        end
    end

    assign bus.clk_fast = clk_fast_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.HEX0     = hex0_q;
    assign bus.HEX1     = hex1_q;
    assign bus.HEX2     = hex2_q;
    assign bus.HEX3     = hex3_q;

endmodule

// File: tb/tb_tron_game_timer.sv
// tb_tron_game_timer
// Directed bench for tron_game_timer with FAST_DIV=4, SEC_DIV=5.
module tb_tron_game_timer;

    localparam int FAST_DIV = 4;
    localparam int SEC_DIV  = 5;

    logic CLOCK_50 = 1'b0;
    logic resetn;

    always #10 CLOCK_50 = ~CLOCK_50;

    tron_game_timer_if bus ();

    tron_game_timer #(
        .FAST_DIV (FAST_DIV),
        .SEC_DIV  (SEC_DIV)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int secs   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic check_time(input string tag);
        int s0, s1, m0, m1;
        logic [6:0] e2, e3;
        s0 = secs % 10;
        s1 = (secs / 10) % 6;
        m0 = (secs / 60) % 10;
        m1 = (secs / 600) % 10;
`ifdef TIMER_LEADING_BLANK_EN
        e3 = (m1 == 0) ? 7'b1111111 : seg(m1);
        e2 = (m1 == 0 && m0 == 0) ? 7'b1111111 : seg(m0);
`else
        e3 = seg(m1);
        e2 = seg(m0);
`endif
        check_val({tag, "_hex0"}, 32'(bus.HEX0), 32'(seg(s0)));
        check_val({tag, "_hex1"}, 32'(bus.HEX1), 32'(seg(s1)));
        check_val({tag, "_hex2"}, 32'(bus.HEX2), 32'(e2));
        check_val({tag, "_hex3"}, 32'(bus.HEX3), 32'(e3));
    endtask

    // Advance until n ticks have been observed; each wait is bounded.
    task automatic run_secs(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin
                step(1);
                k++;
            end while (bus.sec_tick !== 1'b1 && k < SEC_DIV + 2);
            if (bus.sec_tick !== 1'b1)
                check_val("tick_timeout", 32'(bus.sec_tick), 32'd1);
        end
        secs = (secs + n) % 6000;
    endtask

    initial begin
        int ticks;
        int bad;
        logic       clk_hold;
        logic [6:0] h0, h1, h2, h3;

        resetn     = 1'b0;
        bus.enable = 1'b0;
        step(3);
        check_val("rst_clk_fast", 32'(bus.clk_fast), 32'd0);
        check_val("rst_sec_tick", 32'(bus.sec_tick), 32'd0);
        check_val("rst_hex0", 32'(bus.HEX0), 32'h40);
        check_val("rst_hex1", 32'(bus.HEX1), 32'h40);
        check_val("rst_hex2", 32'(bus.HEX2), 32'h40);
        check_val("rst_hex3", 32'(bus.HEX3), 32'h40);

        // clk_fast toggles on every 2nd enabled edge; tick on every 5th.
        resetn     = 1'b1;
        bus.enable = 1'b1;
        ticks      = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check_val($sformatf("clk_fast_e%0d", k), 32'(bus.clk_fast), 32'((k / 2) % 2));
            check_val($sformatf("sec_tick_e%0d", k), 32'(bus.sec_tick), 32'(k % 5 == 0));
            if (bus.sec_tick === 1'b1) ticks++;
        end
        check_val("tick_count_20", 32'(ticks), 32'd4);
        step(1);
        check_val("hex0_three", 32'(bus.HEX0), 32'b0110000);
        step(1);
        check_val("hex0_four", 32'(bus.HEX0), 32'b0011001);
        secs = 4;
        check_time("t_00_04");

        for (int i = 0; i < 6; i++) begin
            run_secs(1);
            step(2);
            check_time($sformatf("t_%0d", secs));
        end

        run_secs(589);
        step(2);
        check_time("t_09_59");
        run_secs(1);
        step(2);
        check_time("t_10_00");
        check_val("t_10_00_hex3_lit", 32'(bus.HEX3), 32'b1111001);
        check_val("t_10_00_hex0_lit", 32'(bus.HEX0), 32'b1000000);

        run_secs(5399);
        step(2);
        check_time("t_99_59");
        run_secs(1);
        step(2);
        check_time("t_wrap");
        check_val("t_wrap_hex1_lit", 32'(bus.HEX1), 32'b1000000);

        run_secs(7);
        step(2);
        check_time("t_00_07");
        check_val("t_00_07_hex0_lit", 32'(bus.HEX0), 32'b1111000);

        // Second divider sits at 2 here; pause must hold everything.
        clk_hold   = bus.clk_fast;
        h0 = bus.HEX0; h1 = bus.HEX1; h2 = bus.HEX2; h3 = bus.HEX3;
        bus.enable = 1'b0;
        bad        = 0;
        repeat (100) begin
            step(1);
            if (bus.sec_tick !== 1'b0 || bus.clk_fast !== clk_hold ||
                bus.HEX0 !== h0 || bus.HEX1 !== h1 || bus.HEX2 !== h2 || bus.HEX3 !== h3)
                bad++;
        end
        check_val("pause_hold", 32'(bad), 32'd0);
        bus.enable = 1'b1;
        step(2);
        check_val("resume_no_tick_yet", 32'(bus.sec_tick), 32'd0);
        step(1);
        check_val("resume_tick", 32'(bus.sec_tick), 32'd1);
        step(1);

        // Reset mid-second: everything clears, full second needed afterwards.
        resetn = 1'b0;
        step(1);
        check_val("midrst_hex0", 32'(bus.HEX0), 32'h40);
        check_val("midrst_tick", 32'(bus.sec_tick), 32'd0);
        check_val("midrst_clk_fast", 32'(bus.clk_fast), 32'd0);
        resetn = 1'b1;
        step(4);
        check_val("postrst_no_tick", 32'(bus.sec_tick), 32'd0);
        step(1);
        check_val("postrst_tick", 32'(bus.sec_tick), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
